// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg: shared constants for the RGB565 LCD timing generator.
// Holds the pattern mode encoding, the colour-bar table and the RGB565 field widths.
package lcd_timing_pkg;

  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int RGB_W = R_W + G_W + B_W;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRAD  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  localparam logic [RGB_W-1:0] RGB_WHITE = 16'hFFFF;
  localparam logic [RGB_W-1:0] RGB_BLACK = 16'h0000;

  // Bar colours, index 0 (left) .. 7 (right); packed so entry i is BAR_TABLE[i].
  localparam logic [7:0][RGB_W-1:0] BAR_TABLE = {
    16'h0000,  // 7 black
    16'h001F,  // 6 blue
    16'hF800,  // 5 red
    16'hF81F,  // 4 magenta
    16'h07E0,  // 3 green
    16'h07FF,  // 2 cyan
    16'hFFE0,  // 1 yellow
    16'hFFFF   // 0 white
  };

endpackage

// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: test-pattern colour source for lcd_timing_gen.
// Bar position is tracked with a per-line pixel counter instead of a divider.
// Build option LCD_TIMING_GEN_SCROLL_EN: per-frame offset register animating the gradient.
module lcd_pattern_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = 480,
  parameter int CW       = 12
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             line_start,
  input  logic             active,
  input  logic             frame_wrap,
  input  logic [CW-1:0]    x,
  input  logic [CW-1:0]    y,
  input  mode_e            mode,
  input  logic [RGB_W-1:0] solid_rgb,
  output logic [R_W-1:0]   r,
  output logic [G_W-1:0]   g,
  output logic [B_W-1:0]   b
);

  localparam int BW = H_ACTIVE / 8;

  logic [CW-1:0]    bar_pix_r;
  logic [2:0]       bar_idx_r;
  logic [CW-1:0]    offset_s;
  logic [8:0]       xs_s;
  logic [8:0]       ys_s;
  logic [RGB_W-1:0] rgb_s;
  logic [RGB_W-1:0] rgb_r;
  logic             unused_bits_s;

  // Bar tracking: count pixels inside the current bar, step the index each BW pixels, park on bar 7.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bar_pix_r <= '0;
      bar_idx_r <= 3'd0;
    end else if (line_start) begin
      bar_pix_r <= '0;
      bar_idx_r <= 3'd0;
    end else if (active) begin
      if ((bar_pix_r == CW'(BW - 1)) && (bar_idx_r != 3'd7)) begin
        bar_pix_r <= '0;
        bar_idx_r <= bar_idx_r + 3'd1;
      end else begin
        bar_pix_r <= bar_pix_r + CW'(1);
        bar_idx_r <= bar_idx_r;
      end
    end else begin
      bar_pix_r <= bar_pix_r;
      bar_idx_r <= bar_idx_r;
    end
  end

`ifdef LCD_TIMING_GEN_SCROLL_EN
  logic [CW-1:0] offset_r;

  // Gradient scroll offset: advances once per frame and wraps at 2^CW.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      offset_r <= '0;
    end else if (frame_wrap) begin
      offset_r <= offset_r + CW'(1);
    end else begin
      offset_r <= offset_r;
    end
  end

  assign offset_s      = offset_r;
  assign unused_bits_s = ^{x, y, offset_s};
`else
  assign offset_s      = '0;
  assign unused_bits_s = ^{x, y, offset_s, frame_wrap};
`endif

  assign xs_s = 9'(x + offset_s);
  assign ys_s = 9'(y + offset_s);

  // Colour mux for the current pixel; blank outside the active area.
  always_comb begin
    rgb_s = RGB_BLACK;
    if (active) begin
      case (mode)
        MODE_BARS:  rgb_s = BAR_TABLE[bar_idx_r];
        MODE_GRAD:  rgb_s = {xs_s[8:4], 6'd63 - xs_s[8:3], ys_s[8:4]};
        MODE_CHECK: rgb_s = (x[4] ^ y[4]) ? RGB_WHITE : RGB_BLACK;
        MODE_SOLID: rgb_s = solid_rgb;
        default:    rgb_s = RGB_BLACK;
      endcase
    end else begin
      rgb_s = RGB_BLACK;
    end
  end

  // Output register so RGB lines up with the registered syncs and DE.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rgb_r <= RGB_BLACK;
    end else begin
      rgb_r <= rgb_s;
    end
  end

  assign r = rgb_r[RGB_W-1 -: R_W];
  assign g = rgb_r[B_W +: G_W];
  assign b = rgb_r[B_W-1:0];

endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: RGB565 parallel-LCD timing and test-pattern generator (PixelClk domain).
// Counters, sync/DE decode, frame-atomic mode latch; colours come from lcd_pattern_gen.
// Build option LCD_TIMING_GEN_SCROLL_EN: scrolling gradient (see lcd_pattern_gen).
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int   H_ACTIVE = 480,
  parameter int   H_FP     = 8,
  parameter int   H_SYNC   = 1,
  parameter int   H_BP     = 43,
  parameter int   V_ACTIVE = 272,
  parameter int   V_FP     = 4,
  parameter int   V_SYNC   = 10,
  parameter int   V_BP     = 12,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 12
) (
  input  logic             PixelClk,
  input  logic             ARST_N,
  input  logic [1:0]       mode,
  input  logic [RGB_W-1:0] solid_rgb,
  output logic             frame_start,
  output logic [CW-1:0]    pix_x,
  output logic [CW-1:0]    pix_y,
  output logic             LCD_DE,
  output logic             LCD_HSYNC,
  output logic             LCD_VSYNC,
  output logic [R_W-1:0]   LCD_R,
  output logic [G_W-1:0]   LCD_G,
  output logic [B_W-1:0]   LCD_B
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam int H_END   = H_START + H_ACTIVE;
  localparam int V_END   = V_START + V_ACTIVE;

  // Elaboration-time rejection of degenerate or oversized timing.
  if ((H_ACTIVE < 8) || (H_FP < 1) || (H_SYNC < 1) || (H_BP < 1) ||
      (V_ACTIVE < 1) || (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1) || (CW < 5) ||
      (H_TOTAL >= (1 << CW)) || (V_TOTAL >= (1 << CW))) begin : g_param_check
    $error("lcd_timing_gen: unsupported timing parameters");
  end

  logic [CW-1:0]    h_cnt_r;
  logic [CW-1:0]    v_cnt_r;
  logic             h_last_s;
  logic             v_last_s;
  logic             active_s;
  logic             first_pix_s;
  logic             frame_top_s;
  logic [CW-1:0]    x_s;
  logic [CW-1:0]    y_s;
  mode_e            mode_r;
  logic [RGB_W-1:0] solid_r;
  logic             de_r;
  logic             hs_r;
  logic             vs_r;
  logic             fs_r;
  logic [CW-1:0]    pix_x_r;
  logic [CW-1:0]    pix_y_r;

  assign h_last_s    = (h_cnt_r == CW'(H_TOTAL - 1));
  assign v_last_s    = (v_cnt_r == CW'(V_TOTAL - 1));
  assign active_s    = (h_cnt_r >= CW'(H_START)) && (h_cnt_r < CW'(H_END)) &&
                       (v_cnt_r >= CW'(V_START)) && (v_cnt_r < CW'(V_END));
  assign first_pix_s = (h_cnt_r == CW'(H_START)) && (v_cnt_r == CW'(V_START));
  assign frame_top_s = (h_cnt_r == '0) && (v_cnt_r == '0);
  assign x_s         = h_cnt_r - CW'(H_START);
  assign y_s         = v_cnt_r - CW'(V_START);

  // Horizontal and vertical raster counters.
  always_ff @(posedge PixelClk or negedge ARST_N) begin
    if (!ARST_N) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else if (h_last_s) begin
      h_cnt_r <= '0;
      v_cnt_r <= v_last_s ? '0 : v_cnt_r + CW'(1);
    end else begin
      h_cnt_r <= h_cnt_r + CW'(1);
      v_cnt_r <= v_cnt_r;
    end
  end

  // Frame-atomic capture of the pattern selection at the top-left of the raster.
  always_ff @(posedge PixelClk or negedge ARST_N) begin
    if (!ARST_N) begin
      mode_r  <= MODE_BARS;
      solid_r <= '0;
    end else if (frame_top_s) begin
      mode_r  <= mode_e'(mode);
      solid_r <= solid_rgb;
    end else begin
      mode_r  <= mode_r;
      solid_r <= solid_r;
    end
  end

  // Registered timing outputs, one cycle behind the counters like the RGB path.
  always_ff @(posedge PixelClk or negedge ARST_N) begin
    if (!ARST_N) begin
      de_r    <= 1'b0;
      hs_r    <= ~HS_POL;
      vs_r    <= ~VS_POL;
      fs_r    <= 1'b0;
      pix_x_r <= '0;
      pix_y_r <= '0;
    end else begin
      de_r    <= active_s;
      hs_r    <= (h_cnt_r < CW'(H_SYNC)) ? HS_POL : ~HS_POL;
      vs_r    <= (v_cnt_r < CW'(V_SYNC)) ? VS_POL : ~VS_POL;
      fs_r    <= first_pix_s;
      pix_x_r <= active_s ? x_s : pix_x_r;
      pix_y_r <= active_s ? y_s : pix_y_r;
    end
  end

  lcd_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .CW       (CW)
  ) u_pattern (
    .clk        (PixelClk),
    .arst_n     (ARST_N),
    .line_start (h_cnt_r == '0),
    .active     (active_s),
    .frame_wrap (h_last_s && v_last_s),
    .x          (x_s),
    .y          (y_s),
    .mode       (mode_r),
    .solid_rgb  (solid_r),
    .r          (LCD_R),
    .g          (LCD_G),
    .b          (LCD_B)
  );

  assign LCD_DE      = de_r;
  assign LCD_HSYNC   = hs_r;
  assign LCD_VSYNC   = vs_r;
  assign frame_start = fs_r;
  assign pix_x       = pix_x_r;
  assign pix_y       = pix_y_r;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: scoreboard bench for lcd_timing_gen using a 24x8 raster.
module tb_lcd_timing_gen;

  localparam int HA = 16;
  localparam int HT = 24;
  localparam int VT = 8;
  localparam int HST = 6;
  localparam int VST = 3;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [11:0] px;
    logic [11:0] py;
    logic [15:0] rgb;
  } obs_t;

  localparam obs_t RST_OBS = '{de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, px: 12'd0, py: 12'd0, rgb: 16'h0000};

  logic        clk = 1'b0;
  logic        arst_n;
  logic [1:0]  mode;
  logic [15:0] solid_rgb;
  logic        frame_start, de, hs, vs;
  logic [11:0] pix_x, pix_y;
  logic [4:0]  r, b;
  logic [5:0]  g;

  int checks = 0;
  int failures = 0;

  obs_t        sb_q[$];
  int          mh, mv;
  logic [1:0]  m_mode;
  logic [15:0] m_solid;
  logic [11:0] m_off, m_px, m_py;
  int          frame_wraps = 0;

  always #5 clk = ~clk;

  lcd_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(12)
  ) dut (
    .PixelClk(clk), .ARST_N(arst_n), .mode(mode), .solid_rgb(solid_rgb),
    .frame_start(frame_start), .pix_x(pix_x), .pix_y(pix_y),
    .LCD_DE(de), .LCD_HSYNC(hs), .LCD_VSYNC(vs),
    .LCD_R(r), .LCD_G(g), .LCD_B(b)
  );

  function automatic logic [15:0] pattern_ref(logic [1:0] md, logic [15:0] sol, int x, int y, logic [11:0] off);
    logic [11:0] xv, yv, xs, ys;
    int idx;
    xv = 12'(x);
    yv = 12'(y);
    xs = xv + off;
    ys = yv + off;
    case (md)
      2'd0: begin
        idx = x / (HA / 8);
        if (idx > 7) idx = 7;
        case (idx)
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      2'd1: return {xs[8:4], 6'(6'd63 - xs[8:3]), ys[8:4]};
      2'd2: return (xv[4] ^ yv[4]) ? 16'hFFFF : 16'h0000;
      default: return sol;
    endcase
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; m_mode = 2'd0; m_solid = 16'h0000;
    m_off = 12'd0; m_px = 12'd0; m_py = 12'd0; frame_wraps = 0;
    sb_q.delete();
  endtask

  // One pixel clock: push the expected output for the current raster position, advance the model, pop and sample.
  task automatic tick(output obs_t got, output obs_t exp);
    obs_t e;
    logic act;
    @(posedge clk);
    act = (mh >= HST) && (mh < HST + HA) && (mv >= VST) && (mv < VST + 4);
    if (act) begin
      m_px = 12'(mh - HST);
      m_py = 12'(mv - VST);
    end
    e.de  = act;
    e.hs  = (mh < 2) ? 1'b0 : 1'b1;
    e.vs  = (mv < 2) ? 1'b0 : 1'b1;
    e.fs  = (mh == HST) && (mv == VST);
    e.px  = m_px;
    e.py  = m_py;
    e.rgb = act ? pattern_ref(m_mode, m_solid, mh - HST, mv - VST, m_off) : 16'h0000;
    sb_q.push_back(e);
    if (mh == 0 && mv == 0) begin
      m_mode = mode;
      m_solid = solid_rgb;
    end
    if (mh == HT - 1 && mv == VT - 1) begin
      frame_wraps++;
`ifdef LCD_TIMING_GEN_SCROLL_EN
      m_off = m_off + 12'd1;
`endif
    end
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end
    #1;
    got = {de, hs, vs, frame_start, pix_x, pix_y, r, g, b};
    exp = sb_q.pop_front();
  endtask

  task automatic test_reset();
    obs_t got, exp;
    arst_n = 1'b0; mode = 2'd0; solid_rgb = 16'h0000;
    #23;
    got = {de, hs, vs, frame_start, pix_x, pix_y, r, g, b};
    checks++;
    if (got !== RST_OBS) begin failures++; $display("FAIL reset_values: got %h want %h", got, RST_OBS); end
    @(negedge clk);
    arst_n = 1'b1;
    model_reset();
    tick(got, exp);
    checks++;
    if (got !== exp) begin failures++; $display("FAIL first_cycle: got %h want %h", got, exp); end
    checks++;
    if (got.hs !== 1'b0 || got.vs !== 1'b0) begin failures++; $display("FAIL first_syncs: got hs=%b vs=%b want 0 0", got.hs, got.vs); end
  endtask

  task automatic test_timing();
    obs_t got, exp;
    int de_cnt = 0, hs_low = 0, vs_low = 0, run = 0, max_run = 0, bad_per = 0, n_per = 0, last_fall = -1;
    logic prev_hs = 1'b0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      tick(got, exp);
      checks++;
      if (got !== exp) begin failures++; $display("FAIL timing_sb: got %h want %h", got, exp); end
      if (got.de) begin de_cnt++; run++; if (run > max_run) max_run = run; end else run = 0;
      if (!got.hs) hs_low++;
      if (!got.vs) vs_low++;
      if (prev_hs && !got.hs) begin
        if (last_fall >= 0) begin n_per++; if (i - last_fall != HT) bad_per++; end
        last_fall = i;
      end
      prev_hs = got.hs;
    end
    checks++;
    if (de_cnt != 128) begin failures++; $display("FAIL de_count: got %0d want 128", de_cnt); end
    checks++;
    if (max_run != 16) begin failures++; $display("FAIL de_run: got %0d want 16", max_run); end
    checks++;
    if (hs_low != 32) begin failures++; $display("FAIL hsync_low: got %0d want 32", hs_low); end
    checks++;
    if (vs_low != 96) begin failures++; $display("FAIL vsync_low: got %0d want 96", vs_low); end
    checks++;
    if (bad_per != 0 || n_per != 15) begin failures++; $display("FAIL hsync_period: got bad=%0d n=%0d want 0 15", bad_per, n_per); end
  endtask

  task automatic test_bars();
    obs_t got, exp;
    logic [15:0] line_px [16];
    for (int i = 0; i < 16; i++) line_px[i] = 16'h1234;
    for (int i = 0; i < HT * VT; i++) begin
      tick(got, exp);
      checks++;
      if (got !== exp) begin failures++; $display("FAIL bars_sb: got %h want %h", got, exp); end
      if (got.de && got.py == 12'd0 && got.px < 12'd16) line_px[got.px] = got.rgb;
    end
    checks++;
    if (line_px[0] !== 16'hFFFF || line_px[1] !== 16'hFFFF) begin failures++; $display("FAIL bar_white: got %h %h want ffff", line_px[0], line_px[1]); end
    checks++;
    if (line_px[2] !== 16'hFFE0) begin failures++; $display("FAIL bar_yellow: got %h want ffe0", line_px[2]); end
    checks++;
    if (line_px[10] !== 16'hF800) begin failures++; $display("FAIL bar_red: got %h want f800", line_px[10]); end
    checks++;
    if (line_px[14] !== 16'h0000 || line_px[15] !== 16'h0000) begin failures++; $display("FAIL bar_black: got %h %h want 0000", line_px[14], line_px[15]); end
  endtask

  task automatic sync_frame(input string tag);
    obs_t got, exp;
    int n = 0;
    while (!(mh == 0 && mv == 0) && n < 300) begin
      tick(got, exp);
      n++;
      checks++;
      if (got !== exp) begin failures++; $display("FAIL %s_sync_sb: got %h want %h", tag, got, exp); end
    end
    checks++;
    if (!(mh == 0 && mv == 0)) begin failures++; $display("FAIL %s_sync: no frame boundary in %0d cycles", tag, n); end
  endtask

  task automatic test_solid();
    obs_t got, exp;
    int bad = 0, de_seen = 0;
    mode = 2'd3; solid_rgb = 16'hF800;
    sync_frame("solid");
    for (int i = 0; i < HT * VT; i++) begin
      tick(got, exp);
      checks++;
      if (got !== exp) begin failures++; $display("FAIL solid_sb: got %h want %h", got, exp); end
      if (got.de) begin de_seen++; if (got.rgb !== 16'hF800) bad++; end
      else if (got.rgb !== 16'h0000) bad++;
    end
    checks++;
    if (bad != 0 || de_seen != 64) begin failures++; $display("FAIL solid_pixels: got bad=%0d de=%0d want 0 64", bad, de_seen); end
  endtask

  task automatic test_mode_switch();
    obs_t got, exp;
    int bad = 0, de_seen = 0, fs_seen = 0;
    for (int i = 0; i < HT * VT; i++) begin
      if (i == 96) mode = 2'd2;
      tick(got, exp);
      checks++;
      if (got !== exp) begin failures++; $display("FAIL switch_sb: got %h want %h", got, exp); end
      if (i >= 96 && got.de) begin de_seen++; if (got.rgb !== 16'hF800) bad++; end
    end
    checks++;
    if (bad != 0 || de_seen != 48) begin failures++; $display("FAIL switch_rest_solid: got bad=%0d de=%0d want 0 48", bad, de_seen); end
    for (int i = 0; i < HT * VT; i++) begin
      tick(got, exp);
      checks++;
      if (got !== exp) begin failures++; $display("FAIL checker_sb: got %h want %h", got, exp); end
      if (got.fs) begin
        fs_seen++;
        checks++;
        if (got.rgb !== 16'h0000 || got.px !== 12'd0 || got.py !== 12'd0 || got.de !== 1'b1)
          begin failures++; $display("FAIL checker_origin: got rgb=%h x=%0d y=%0d de=%b want 0000 0 0 1", got.rgb, got.px, got.py, got.de); end
      end
    end
    checks++;
    if (fs_seen != 1) begin failures++; $display("FAIL checker_frame_start: got %0d pulses want 1", fs_seen); end
  endtask

  task automatic test_gradient();
    obs_t got, exp;
    int sum, sum0 = 0, nfr;
    logic [11:0] n;
    mode = 2'd1;
`ifdef LCD_TIMING_GEN_SCROLL_EN
    nfr = 18;
`else
    nfr = 3;
`endif
    sync_frame("grad");
    for (int f = 0; f < nfr; f++) begin
      sum = 0;
      for (int i = 0; i < HT * VT; i++) begin
        tick(got, exp);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL grad_sb: got %h want %h", got, exp); end
        if (got.de) sum = sum * 3 + int'(got.rgb) + int'(got.px);
        if (got.fs && f > 0) begin
          n = 12'(frame_wraps);
`ifdef LCD_TIMING_GEN_SCROLL_EN
          checks++;
          if (got.rgb[15:11] !== n[8:4] || got.rgb[10:5] !== 6'(6'd63 - n[8:3]))
            begin failures++; $display("FAIL grad_scroll: got rgb=%h want R=%0d G=%0d", got.rgb, n[8:4], 6'(6'd63 - n[8:3])); end
`else
          checks++;
          if (got.rgb !== 16'h07E0) begin failures++; $display("FAIL grad_static_origin: got %h want 07e0", got.rgb); end
`endif
        end
      end
      if (f == 0) sum0 = sum;
`ifndef LCD_TIMING_GEN_SCROLL_EN
      else begin
        checks++;
        if (sum != sum0) begin failures++; $display("FAIL grad_identical: got %0d want %0d", sum, sum0); end
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, exp;
    int n = 0, lat = 0;
    while (!(mh == 10 && mv == 4) && n < 400) begin
      tick(got, exp);
      n++;
      checks++;
      if (got !== exp) begin failures++; $display("FAIL midrst_sb: got %h want %h", got, exp); end
    end
    checks++;
    if (got.de !== 1'b1) begin failures++; $display("FAIL midrst_pre_de: got %b want 1", got.de); end
    #2;
    arst_n = 1'b0;
    #1;
    got = {de, hs, vs, frame_start, pix_x, pix_y, r, g, b};
    checks++;
    if (got !== RST_OBS) begin failures++; $display("FAIL midrst_async: got %h want %h", got, RST_OBS); end
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    model_reset();
    got.fs = 1'b0;
    // counters restart at 0, so the first pixel is 3 lines plus 6 pixels away, seen one edge later
    while (!got.fs && lat < 300) begin
      tick(got, exp);
      lat++;
      checks++;
      if (got !== exp) begin failures++; $display("FAIL postrst_sb: got %h want %h", got, exp); end
    end
    checks++;
    if (lat != VST * HT + HST + 1) begin failures++; $display("FAIL postrst_frame_start: got %0d edges want %0d", lat, VST * HT + HST + 1); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_bars();
    test_solid();
    test_mode_switch();
    test_gradient();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
